wr_port_decoder: RTL and testbench

WR_PORT_DECODER -- requirements
Module: wr_port_decoder

---
 rtl/wr_port_decoder_if.sv | 29 ++
 rtl/wr_port_decoder.sv | 90 +++++++++
 tb/tb_wr_port_decoder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/wr_port_decoder_if.sv
// Bus bundle for the dual write-port register decoder: request inputs
// plus the registered decode outputs.
interface wr_port_decoder_if #(
  parameter int AW = 3,
  parameter int CW = 8
);
  localparam int NREG = 2 ** AW;

  logic            EN0;
  logic [AW-1:0]   ADDR0;
  logic            EN1;
  logic [AW-1:0]   ADDR1;
  logic            CLR;
  logic [NREG-1:0] WE;
  logic [NREG-1:0] WSRC;
  logic            COLLIDE;
  logic            PROT_HIT;
  logic [CW-1:0]   COLL_CNT;

  modport master (
    output EN0, ADDR0, EN1, ADDR1, CLR,
    input  WE, WSRC, COLLIDE, PROT_HIT, COLL_CNT
  );

  modport slave (
    input  EN0, ADDR0, EN1, ADDR1, CLR,
    output WE, WSRC, COLLIDE, PROT_HIT, COLL_CNT
  );
endinterface

// File: rtl/wr_port_decoder.sv
// Two write ports decoded to one-hot register write enables with a data
// source select; port 0 wins same-register collisions, which are counted.
module wr_port_decoder #(
  parameter int AW        = 3,
  parameter int NREG      = 2 ** AW,
  parameter int ZERO_PROT = 0,
  parameter int CW        = 8
) (
  input  logic               CLK,
  input  logic               RESETN,
  wr_port_decoder_if.slave   bus
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic [NREG-1:0] w_we_p0;
  logic [NREG-1:0] w_wsrc_p0;
  logic            w_coll_p0;
  logic            w_prot_p0;
  logic [CW-1:0]   w_cnt_p0;

  logic [NREG-1:0] r_we_p1;
  logic [NREG-1:0] r_wsrc_p1;
  logic            r_coll_p1;
  logic            r_prot_p1;
  logic [CW-1:0]   r_cnt_p1;

  // Stage p0: combinational decode of the sampled requests
  always_comb begin
    w_we_p0   = '0;
    w_wsrc_p0 = '0;
    w_prot_p0 = 1'b0;
    w_coll_p0 = bus.EN0 && bus.EN1 && (bus.ADDR0 == bus.ADDR1);

    if (bus.EN1 && !w_coll_p0) begin
      if ((ZERO_PROT != 0) && (bus.ADDR1 == '0)) begin
        w_prot_p0 = 1'b1;
      end else begin
        w_we_p0[bus.ADDR1]   = 1'b1;
        w_wsrc_p0[bus.ADDR1] = 1'b1;
      end
    end

    if (bus.EN0) begin
      if ((ZERO_PROT != 0) && (bus.ADDR0 == '0)) begin
        w_prot_p0 = 1'b1;
      end else begin
        w_we_p0[bus.ADDR0]   = 1'b1;
        w_wsrc_p0[bus.ADDR0] = 1'b0;
      end
    end

    // Clear beats a coincident collision; the pulse itself is unaffected
    if (bus.CLR) begin
      w_cnt_p0 = '0;
    end else if (w_coll_p0) begin
      w_cnt_p0 = sat_inc(r_cnt_p1);
    end else begin
      w_cnt_p0 = r_cnt_p1;
    end
  end

  // Stage p1: output registers
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_we_p1   <= '0;
      r_wsrc_p1 <= '0;
      r_coll_p1 <= 1'b0;
      r_prot_p1 <= 1'b0;
      r_cnt_p1  <= '0;
    end else begin
      r_we_p1   <= w_we_p0;
      r_wsrc_p1 <= w_wsrc_p0;
      r_coll_p1 <= w_coll_p0;
      r_prot_p1 <= w_prot_p0;
      r_cnt_p1  <= w_cnt_p0;
    end
  end

  assign bus.WE       = r_we_p1;
  assign bus.WSRC     = r_wsrc_p1;
  assign bus.COLLIDE  = r_coll_p1;
  assign bus.PROT_HIT = r_prot_p1;
  assign bus.COLL_CNT = r_cnt_p1;

endmodule

// File: tb/tb_wr_port_decoder.sv
// Bench for wr_port_decoder: AW=3 unprotected/CW=8, AW=3 protected/CW=2,
// and an AW=5 sweep instance sharing one clock and reset.
module tb_wr_port_decoder;

  logic CLK;
  logic RESETN;

  wr_port_decoder_if #(.AW(3), .CW(8)) ifa ();
  wr_port_decoder_if #(.AW(3), .CW(2)) ifp ();
  wr_port_decoder_if #(.AW(5), .CW(8)) ifw ();

  wr_port_decoder #(.AW(3), .NREG(8), .ZERO_PROT(0), .CW(8)) dut_a (
    .CLK(CLK), .RESETN(RESETN), .bus(ifa.slave));
  wr_port_decoder #(.AW(3), .NREG(8), .ZERO_PROT(1), .CW(2)) dut_p (
    .CLK(CLK), .RESETN(RESETN), .bus(ifp.slave));
  wr_port_decoder #(.AW(5), .NREG(32), .ZERO_PROT(0), .CW(8)) dut_w (
    .CLK(CLK), .RESETN(RESETN), .bus(ifw.slave));

  typedef struct packed {
    logic [31:0] we;
    logic [31:0] wsrc;
    logic        coll;
    logic        prot;
    logic [7:0]  cnt;
  } exp_t;

  typedef struct packed {
    bit       rstn;
    bit       en0;
    bit [2:0] a0;
    bit       en1;
    bit [2:0] a1;
    bit       clr;
    bit [7:0] we;
    bit [7:0] wsrc;
    bit       coll;
    bit       prot;
    bit [7:0] cnt;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  exp_t qa[$];
  exp_t qp[$];
  logic [31:0] qw[$];

  int errors = 0;
  int checks = 0;
  logic [7:0] mcnt_p = 8'd0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Independent reference for the protected CW=2 instance
  function automatic exp_t model_p(input bit rstn, input bit en0, input bit [2:0] a0,
                                   input bit en1, input bit [2:0] a1, input bit clr);
    exp_t e;
    e = '0;
    if (!rstn) begin
      mcnt_p = 8'd0;
      return e;
    end
    e.coll = en0 && en1 && (a0 == a1);
    if (en0) begin
      if (a0 == 3'd0) e.prot = 1'b1;
      else e.we = e.we | (32'd1 << a0);
    end
    if (en1 && !e.coll) begin
      if (a1 == 3'd0) begin
        e.prot = 1'b1;
      end else begin
        e.we   = e.we   | (32'd1 << a1);
        e.wsrc = e.wsrc | (32'd1 << a1);
      end
    end
    if (clr) mcnt_p = 8'd0;
    else if (e.coll && mcnt_p < 8'd3) mcnt_p = mcnt_p + 8'd1;
    e.cnt = mcnt_p;
    return e;
  endfunction

  task automatic cmp_bus(input string tag, input exp_t e, input logic [31:0] we,
                         input logic [31:0] wsrc, input logic coll, input logic prot,
                         input logic [7:0] cnt);
    chk({tag, ".WE"},       we,           e.we);
    chk({tag, ".WSRC"},     wsrc,         e.wsrc);
    chk({tag, ".COLLIDE"},  32'(coll),    32'(e.coll));
    chk({tag, ".PROT_HIT"}, 32'(prot),    32'(e.prot));
    chk({tag, ".COLL_CNT"}, 32'(cnt),     32'(e.cnt));
  endtask

  // One cycle on the two AW=3 instances: drive, push expectations, pop after the edge
  task automatic apply(input string tag, input bit rstn, input bit en0, input bit [2:0] a0,
                       input bit en1, input bit [2:0] a1, input bit clr, input exp_t ea);
    exp_t e;
    @(negedge CLK);
    RESETN = rstn;
    ifa.EN0 = en0; ifa.ADDR0 = a0; ifa.EN1 = en1; ifa.ADDR1 = a1; ifa.CLR = clr;
    ifp.EN0 = en0; ifp.ADDR0 = a0; ifp.EN1 = en1; ifp.ADDR1 = a1; ifp.CLR = clr;
    qa.push_back(ea);
    qp.push_back(model_p(rstn, en0, a0, en1, a1, clr));
    @(posedge CLK);
    #1;
    e = qa.pop_front();
    cmp_bus({tag, "/a"}, e, 32'(ifa.WE), 32'(ifa.WSRC), ifa.COLLIDE, ifa.PROT_HIT,
            8'(ifa.COLL_CNT));
    e = qp.pop_front();
    cmp_bus({tag, "/p"}, e, 32'(ifp.WE), 32'(ifp.WSRC), ifp.COLLIDE, ifp.PROT_HIT,
            8'(ifp.COLL_CNT));
  endtask

  initial begin
    exp_t ea;

    //          rstn en0 a0  en1 a1  clr  we     wsrc   coll prot cnt
    tbl[0]  = '{1'b1,1'b0,3'd0,1'b0,3'd0,1'b0, 8'h00, 8'h00, 1'b0,1'b0, 8'd0};
    tbl[1]  = '{1'b1,1'b1,3'd5,1'b1,3'd2,1'b0, 8'h24, 8'h04, 1'b0,1'b0, 8'd0};
    tbl[2]  = '{1'b1,1'b1,3'd6,1'b1,3'd6,1'b0, 8'h40, 8'h00, 1'b1,1'b0, 8'd1};
    tbl[3]  = '{1'b1,1'b0,3'd0,1'b0,3'd0,1'b0, 8'h00, 8'h00, 1'b0,1'b0, 8'd1};
    tbl[4]  = '{1'b1,1'b1,3'd3,1'b1,3'd0,1'b0, 8'h09, 8'h01, 1'b0,1'b0, 8'd1};
    tbl[5]  = '{1'b1,1'b0,3'd0,1'b1,3'd7,1'b0, 8'h80, 8'h80, 1'b0,1'b0, 8'd1};
    tbl[6]  = '{1'b1,1'b1,3'd0,1'b0,3'd0,1'b0, 8'h01, 8'h00, 1'b0,1'b0, 8'd1};
    tbl[7]  = '{1'b1,1'b1,3'd0,1'b1,3'd0,1'b0, 8'h01, 8'h00, 1'b1,1'b0, 8'd2};
    tbl[8]  = '{1'b1,1'b1,3'd6,1'b1,3'd6,1'b0, 8'h40, 8'h00, 1'b1,1'b0, 8'd3};
    tbl[9]  = '{1'b1,1'b1,3'd1,1'b1,3'd1,1'b0, 8'h02, 8'h00, 1'b1,1'b0, 8'd4};
    tbl[10] = '{1'b1,1'b1,3'd2,1'b1,3'd2,1'b0, 8'h04, 8'h00, 1'b1,1'b0, 8'd5};
    tbl[11] = '{1'b1,1'b1,3'd4,1'b1,3'd4,1'b1, 8'h10, 8'h00, 1'b1,1'b0, 8'd0};
    tbl[12] = '{1'b1,1'b1,3'd3,1'b1,3'd3,1'b0, 8'h08, 8'h00, 1'b1,1'b0, 8'd1};
    tbl[13] = '{1'b1,1'b1,3'd5,1'b1,3'd5,1'b0, 8'h20, 8'h00, 1'b1,1'b0, 8'd2};
    tbl[14] = '{1'b0,1'b1,3'd4,1'b1,3'd4,1'b0, 8'h00, 8'h00, 1'b0,1'b0, 8'd0};
    tbl[15] = '{1'b1,1'b0,3'd0,1'b0,3'd0,1'b0, 8'h00, 8'h00, 1'b0,1'b0, 8'd0};
    tbl[16] = '{1'b1,1'b1,3'd7,1'b1,3'd7,1'b0, 8'h80, 8'h00, 1'b1,1'b0, 8'd1};
    tbl[17] = '{1'b1,1'b0,3'd0,1'b0,3'd0,1'b1, 8'h00, 8'h00, 1'b0,1'b0, 8'd0};
    tbl[18] = '{1'b0,1'b1,3'd2,1'b1,3'd3,1'b1, 8'h00, 8'h00, 1'b0,1'b0, 8'd0};
    tbl[19] = '{1'b1,1'b1,3'd2,1'b1,3'd3,1'b0, 8'h0c, 8'h08, 1'b0,1'b0, 8'd0};
    tbl[20] = '{1'b1,1'b0,3'd3,1'b1,3'd3,1'b0, 8'h08, 8'h08, 1'b0,1'b0, 8'd0};

    RESETN = 1'b0;
    ifa.EN0 = 1'b1; ifa.ADDR0 = 3'd4; ifa.EN1 = 1'b1; ifa.ADDR1 = 3'd4; ifa.CLR = 1'b0;
    ifp.EN0 = 1'b1; ifp.ADDR0 = 3'd0; ifp.EN1 = 1'b1; ifp.ADDR1 = 3'd0; ifp.CLR = 1'b0;
    ifw.EN0 = 1'b1; ifw.ADDR0 = 5'd9; ifw.EN1 = 1'b1; ifw.ADDR1 = 5'd9; ifw.CLR = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    ea = '0;
    cmp_bus("reset/a", ea, 32'(ifa.WE), 32'(ifa.WSRC), ifa.COLLIDE, ifa.PROT_HIT, 8'(ifa.COLL_CNT));
    cmp_bus("reset/p", ea, 32'(ifp.WE), 32'(ifp.WSRC), ifp.COLLIDE, ifp.PROT_HIT, 8'(ifp.COLL_CNT));
    cmp_bus("reset/w", ea, ifw.WE, ifw.WSRC, ifw.COLLIDE, ifw.PROT_HIT, ifw.COLL_CNT);
    mcnt_p = 8'd0;
    @(negedge CLK);
    ifw.EN0 = 1'b0; ifw.EN1 = 1'b0;

    for (int i = 0; i < NV; i++) begin
      ea      = '0;
      ea.we   = 32'(tbl[i].we);
      ea.wsrc = 32'(tbl[i].wsrc);
      ea.coll = tbl[i].coll;
      ea.prot = tbl[i].prot;
      ea.cnt  = tbl[i].cnt;
      apply($sformatf("vec%0d", i), tbl[i].rstn, tbl[i].en0, tbl[i].a0,
            tbl[i].en1, tbl[i].a1, tbl[i].clr, ea);
    end

    // Saturation of the 2-bit counter, then clear racing a collision
    ea = '0;
    apply("presat_clr", 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, ea);
    for (int i = 0; i < 5; i++) begin
      ea = '0; ea.we = 32'h02; ea.coll = 1'b1; ea.cnt = 8'(i + 1);
      apply($sformatf("sat%0d", i), 1'b1, 1'b1, 3'd1, 1'b1, 3'd1, 1'b0, ea);
      chk($sformatf("sat%0d.cw2_cnt", i), 32'(ifp.COLL_CNT), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    ea = '0; ea.we = 32'h02; ea.coll = 1'b1; ea.cnt = 8'd0;
    apply("clr_coll", 1'b1, 1'b1, 3'd1, 1'b1, 3'd1, 1'b1, ea);
    chk("clr_coll.cw2_collide", 32'(ifp.COLLIDE), 32'd1);
    chk("clr_coll.cw2_cnt", 32'(ifp.COLL_CNT), 32'd0);
    ea = '0;
    apply("idle_after", 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, ea);

    // AW=5 one-hot sweep on port 0
    for (int a = 0; a < 32; a++) begin
      @(negedge CLK);
      ifw.EN0 = 1'b1; ifw.ADDR0 = 5'(a);
      qw.push_back(32'd1 << a);
      @(posedge CLK);
      #1;
      chk($sformatf("sweep%0d.WE", a), ifw.WE, qw.pop_front());
      chk($sformatf("sweep%0d.WSRC", a), ifw.WSRC, 32'd0);
      @(negedge CLK);
      ifw.EN0 = 1'b0;
      qw.push_back(32'd0);
      @(posedge CLK);
      #1;
      chk($sformatf("sweep%0d.idleWE", a), ifw.WE, qw.pop_front());
    end

    chk("queues_drained", 32'(qa.size() + qp.size() + qw.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
